// File: rtl/sa_stream_ctrl.sv
// sa_stream_ctrl: skews X into a weight-stationary systolic array and de-skews its bottom-edge output into a result matrix
// Optional SA_STREAM_ACC_EN adds I_ACC for signed saturating cross-tile accumulation into O_OUT.
module sa_stream_ctrl #(
  parameter int DW      = 16,
  parameter int S       = 64,
  parameter int X_R     = 64,
  parameter int N       = 64,
  parameter int OUT_OFS = 64
) (
  input  logic                  I_CLK,
  input  logic                  I_RST,
  input  logic                  I_START,
`ifdef SA_STREAM_ACC_EN
  input  logic                  I_ACC,
`endif
  input  logic [S*X_R*DW-1:0]   I_X,
  input  logic [S*N*DW-1:0]     I_W,
  output logic [S*N*DW-1:0]     O_SA_W,
  output logic                  O_SA_W_LOAD,
  input  logic                  I_SA_SHIFT,
  output logic [S*DW-1:0]       O_SA_X,
  input  logic [N*DW-1:0]       I_SA_OUT,
  output logic                  O_BUSY,
  output logic                  O_OUT_VLD,
  input  logic                  I_OUT_RDY,
  output logic [X_R*N*DW-1:0]   O_OUT
);
  localparam int T = X_R + N - 1 + OUT_OFS;
  localparam int TW = $clog2(T + 1);
  localparam logic [TW-1:0] T_LAST = TW'(T - 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [S*X_R*DW-1:0] x_q, x_d;
  logic [S*N*DW-1:0] w_q, w_d;
  logic [X_R*N*DW-1:0] out_q, out_d;
  logic acc_q, acc_d, acc_in, start, beat;
`ifdef SA_STREAM_ACC_EN
  assign acc_in = I_ACC;
`else
  assign acc_in = 1'b0;
`endif
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    return (s[DW] != s[DW-1]) ? (s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) : s[DW-1:0];
  endfunction
  assign start = I_START && (state_q == IDLE || state_q == DONE);
  assign beat = I_SA_SHIFT && state_q == RUN;
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    x_d = x_q;
    w_d = w_q;
    acc_d = acc_q;
    out_d = out_q;
    if (start) begin
      state_d = LOAD;
      t_d = '0;
      x_d = I_X;
      w_d = I_W;
      acc_d = acc_in;
    end else if (state_q == LOAD) state_d = RUN;
    else if (state_q == DONE && I_OUT_RDY) state_d = IDLE;
    else if (beat) begin
      state_d = (t_q == T_LAST) ? DONE : RUN;
      t_d = (t_q == T_LAST) ? t_q : t_q + TW'(1);
      // lane c carries row r on beat r+c+OUT_OFS
      for (int c = 0; c < N; c++)
        if (int'(t_q) >= c + OUT_OFS && int'(t_q) < c + OUT_OFS + X_R)
          out_d[((int'(t_q) - c - OUT_OFS) * N + c) * DW +: DW] = acc_q ?
            sat_add(out_q[((int'(t_q) - c - OUT_OFS) * N + c) * DW +: DW], I_SA_OUT[c*DW +: DW]) :
            I_SA_OUT[c*DW +: DW];
    end
  end
  always_comb begin
    O_SA_X = '0;
    for (int k = 0; k < S; k++)
      if (state_q == RUN && int'(t_q) >= k && int'(t_q) < k + X_R)
        O_SA_X[k*DW +: DW] = x_q[(k * X_R + int'(t_q) - k) * DW +: DW];
  end
  always_ff @(posedge I_CLK or posedge I_RST)
    if (I_RST) begin
      state_q <= IDLE;
      t_q <= '0;
      x_q <= '0;
      w_q <= '0;
      out_q <= '0;
      acc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      x_q <= x_d;
      w_q <= w_d;
      out_q <= out_d;
      acc_q <= acc_d;
    end
  assign O_SA_W = w_q;
  assign O_SA_W_LOAD = state_q == LOAD;
  assign O_BUSY = state_q == LOAD || state_q == RUN;
  assign O_OUT_VLD = state_q == DONE;
  assign O_OUT = out_q;
endmodule

// File: tb/tb_sa_stream_ctrl.sv
// tb_sa_stream_ctrl: directed bench for sa_stream_ctrl with a behavioural weight-stationary SA (S=4, X_R=2, N=4, OUT_OFS=4)
module tb_sa_stream_ctrl;
  localparam int DW = 16, S = 4, XR = 2, N = 4, OFS = 4;
  logic clk = 1'b0, rst, start, rdy, sa_shift;
  logic [S*XR*DW-1:0] x;
  logic [S*N*DW-1:0] w, sa_w;
  logic sa_w_load, busy, vld;
  logic [S*DW-1:0] sa_x;
  logic [N*DW-1:0] sa_out;
  logic [XR*N*DW-1:0] out;
`ifdef SA_STREAM_ACC_EN
  logic acc = 1'b0;
`endif
  int errs = 0, checks = 0, b = 0;
  logic [15:0] hist [0:63][0:S-1];
  logic [15:0] wm [0:S-1][0:N-1];
  always #5 clk = ~clk;
  sa_stream_ctrl #(.DW(DW), .S(S), .X_R(XR), .N(N), .OUT_OFS(OFS)) dut (
    .I_CLK(clk), .I_RST(rst), .I_START(start),
`ifdef SA_STREAM_ACC_EN
    .I_ACC(acc),
`endif
    .I_X(x), .I_W(w), .O_SA_W(sa_w), .O_SA_W_LOAD(sa_w_load), .I_SA_SHIFT(sa_shift),
    .O_SA_X(sa_x), .I_SA_OUT(sa_out), .O_BUSY(busy), .O_OUT_VLD(vld), .I_OUT_RDY(rdy), .O_OUT(out)
  );
  // SA model: restarts on weight load, records each consumed left-edge vector, emits Y[b-c-OFS][c] on lane c
  task automatic cyc(input bit sh);
    logic signed [31:0] acc32;
    int r;
    if (sa_w_load) begin
      b = 0;
      for (int k = 0; k < S; k++) for (int c = 0; c < N; c++) wm[k][c] = sa_w[(k*N+c)*DW +: DW];
    end else if (sh && b < 64) begin
      for (int k = 0; k < S; k++) hist[b][k] = sa_x[k*DW +: DW];
      for (int c = 0; c < N; c++) begin
        r = b - c - OFS;
        if (r >= 0 && r < XR) begin
          acc32 = 0;
          for (int k = 0; k < S; k++) acc32 = acc32 + $signed(hist[r+k][k]) * $signed(wm[k][c]);
          sa_out[c*DW +: DW] = 16'(acc32 >>> 13);
        end else sa_out[c*DW +: DW] = 16'hDEAD;
      end
      b++;
    end
    sa_shift = sh;
    @(negedge clk);
  endtask
  task automatic set_x(input logic [63:0] row0, input logic [63:0] row1);
    for (int k = 0; k < S; k++) begin
      x[(k*XR+0)*DW +: DW] = row0[k*DW +: DW];
      x[(k*XR+1)*DW +: DW] = row1[k*DW +: DW];
    end
  endtask
  task automatic go();
    start = 1'b1;
    cyc(1'b1);
    start = 1'b0;
  endtask
  task automatic accept();
    rdy = 1'b1;
    cyc(1'b0);
    rdy = 1'b0;
  endtask
  task automatic run_full(output int lat);
    go();
    lat = 0;
    while (!vld && lat < 200) begin
      cyc(1'b1);
      lat++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rdy = 1'b0; sa_shift = 1'b0; sa_out = '0;
    x = {8{16'h1234}}; w = {16{16'h5555}};
    cyc(1'b0);
    cyc(1'b1);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (vld !== 1'b0) begin errs++; $display("FAIL reset_vld got %b want 0", vld); end
    checks++; if (sa_w_load !== 1'b0) begin errs++; $display("FAIL reset_wload got %b want 0", sa_w_load); end
    checks++; if (sa_x !== '0) begin errs++; $display("FAIL reset_sa_x got %h want 0", sa_x); end
    checks++; if (sa_w !== '0) begin errs++; $display("FAIL reset_sa_w got %h want 0", sa_w); end
    checks++; if (out !== '0) begin errs++; $display("FAIL reset_out got %h want 0", out); end
    rst = 1'b0;
    cyc(1'b0);
  endtask
  task automatic test_basic();
    set_x({4{16'h2000}}, {4{16'h2000}});
    w = {16{16'h0800}};
    go();
    checks++; if (sa_w !== w) begin errs++; $display("FAIL basic_sa_w got %h want %h", sa_w, w); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (sa_w_load !== (i == 0)) begin errs++; $display("FAIL basic_wload cyc%0d got %b", i, sa_w_load); end
      checks++; if (vld !== 1'b0) begin errs++; $display("FAIL basic_vld_early cyc%0d got %b want 0", i, vld); end
      if (i == 1) begin
        checks++; if (sa_x !== {48'h0, 16'h2000}) begin errs++; $display("FAIL basic_skew_t0 got %h want %h", sa_x, {48'h0, 16'h2000}); end
      end
      if (i == 4) begin
        checks++; if (sa_x[63:48] !== 16'h2000) begin errs++; $display("FAIL basic_skew_t3 got %h want 2000", sa_x[63:48]); end
      end
      if (i >= 6) begin
        checks++; if (sa_x !== '0) begin errs++; $display("FAIL basic_flush t%0d got %h want 0", i - 1, sa_x); end
      end
      cyc(1'b1);
    end
    checks++; if (vld !== 1'b1) begin errs++; $display("FAIL basic_vld got %b want 1", vld); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_done got %b want 0", busy); end
    checks++; if (out !== {8{16'h2000}}) begin errs++; $display("FAIL basic_out got %h want %h", out, {8{16'h2000}}); end
    accept();
    checks++; if (vld !== 1'b0) begin errs++; $display("FAIL basic_accept_vld got %b want 0", vld); end
  endtask
  task automatic test_skew();
    logic [63:0] exp_x [6];
    exp_x = '{64'h0000_0000_0000_0400, 64'h0000_0000_0800_2000, 64'h0000_0C00_2000_0000,
              64'h1000_2000_0000_0000, 64'h2000_0000_0000_0000, 64'h0};
    set_x({16'h1000, 16'h0C00, 16'h0800, 16'h0400}, {4{16'h2000}});
    go();
    for (int i = 0; i < 10; i++) begin
      if (i >= 1 && i <= 6) begin
        checks++; if (sa_x !== exp_x[i-1]) begin errs++; $display("FAIL skew t%0d got %h want %h", i - 1, sa_x, exp_x[i-1]); end
      end
      cyc(1'b1);
    end
    checks++; if (vld !== 1'b1) begin errs++; $display("FAIL skew_vld got %b want 1", vld); end
    checks++; if (out !== {{4{16'h2000}}, {4{16'h0A00}}}) begin errs++; $display("FAIL skew_out got %h want %h", out, {{4{16'h2000}}, {4{16'h0A00}}}); end
    accept();
  endtask
  task automatic test_gap();
    set_x({4{16'h2000}}, {4{16'h2000}});
    go();
    for (int i = 0; i < 26; i++) begin
      checks++; if (vld !== 1'b0) begin errs++; $display("FAIL gap_vld_early cyc%0d got %b want 0", i, vld); end
      if (i == 1) begin
        checks++; if (sa_x !== {48'h0, 16'h2000}) begin errs++; $display("FAIL gap_t0 got %h want %h", sa_x, {48'h0, 16'h2000}); end
      end
      if (i == 3 || i == 4) begin
        checks++; if (sa_x !== {32'h0, 32'h2000_2000}) begin errs++; $display("FAIL gap_hold cyc%0d got %h want %h", i, sa_x, {32'h0, 32'h2000_2000}); end
      end
      cyc(i % 3 == 1);
    end
    checks++; if (vld !== 1'b1) begin errs++; $display("FAIL gap_vld got %b want 1", vld); end
    checks++; if (out !== {8{16'h2000}}) begin errs++; $display("FAIL gap_out got %h want %h", out, {8{16'h2000}}); end
  endtask
  task automatic test_backpressure();
    for (int j = 0; j < 5; j++) begin
      cyc(1'b1);
      checks++; if (vld !== 1'b1) begin errs++; $display("FAIL bp_vld cyc%0d got %b want 1", j, vld); end
      checks++; if (out !== {8{16'h2000}}) begin errs++; $display("FAIL bp_out cyc%0d got %h want %h", j, out, {8{16'h2000}}); end
    end
    accept();
    checks++; if (vld !== 1'b0) begin errs++; $display("FAIL bp_rdy_vld got %b want 0", vld); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL bp_rdy_busy got %b want 0", busy); end
  endtask
  task automatic test_restart_ignored();
    set_x({16'h1000, 16'h0C00, 16'h0800, 16'h0400}, {4{16'h2000}});
    go();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL restart_busy got %b want 1", busy); end
        checks++; if (sa_w_load !== 1'b0) begin errs++; $display("FAIL restart_wload got %b want 0", sa_w_load); end
        checks++; if (sa_x !== 64'h2000_0000_0000_0000) begin errs++; $display("FAIL restart_skew got %h want 2000000000000000", sa_x); end
      end
      if (i == 4) begin
        x = {8{16'h3000}};
        start = 1'b1;
      end
      cyc(1'b1);
      start = 1'b0;
    end
    checks++; if (vld !== 1'b1) begin errs++; $display("FAIL restart_vld got %b want 1", vld); end
    checks++; if (out !== {{4{16'h2000}}, {4{16'h0A00}}}) begin errs++; $display("FAIL restart_out got %h want %h", out, {{4{16'h2000}}, {4{16'h0A00}}}); end
    accept();
  endtask
  task automatic test_reset_midrun();
    int lat;
    set_x({4{16'h2000}}, {4{16'h2000}});
    go();
    for (int i = 0; i < 5; i++) cyc(1'b1);
    rst = 1'b1;
    cyc(1'b0);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (out !== '0) begin errs++; $display("FAIL midrst_out got %h want 0", out); end
    checks++; if (sa_x !== '0) begin errs++; $display("FAIL midrst_sa_x got %h want 0", sa_x); end
    checks++; if (sa_w !== '0) begin errs++; $display("FAIL midrst_sa_w got %h want 0", sa_w); end
    rst = 1'b0;
    cyc(1'b0);
    run_full(lat);
    checks++; if (lat !== 10) begin errs++; $display("FAIL midrst_latency got %0d want 10", lat); end
    checks++; if (out !== {8{16'h2000}}) begin errs++; $display("FAIL midrst_out_fresh got %h want %h", out, {8{16'h2000}}); end
    accept();
  endtask
`ifdef SA_STREAM_ACC_EN
  task automatic test_acc();
    int lat;
    set_x({4{16'h2000}}, {4{16'h2000}});
    w = {16{16'h0800}};
    acc = 1'b0;
    run_full(lat);
    checks++; if (out !== {8{16'h2000}}) begin errs++; $display("FAIL acc_run1 got %h want %h", out, {8{16'h2000}}); end
    accept();
    acc = 1'b1;
    run_full(lat);
    checks++; if (out !== {8{16'h4000}}) begin errs++; $display("FAIL acc_run2 got %h want %h", out, {8{16'h4000}}); end
    accept();
    w = {16{16'h1800}};
    acc = 1'b0;
    run_full(lat);
    checks++; if (out !== {8{16'h6000}}) begin errs++; $display("FAIL acc_sat_run1 got %h want %h", out, {8{16'h6000}}); end
    accept();
    acc = 1'b1;
    run_full(lat);
    checks++; if (out !== {8{16'h7FFF}}) begin errs++; $display("FAIL acc_sat_run2 got %h want %h", out, {8{16'h7FFF}}); end
    accept();
    acc = 1'b0;
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_skew();
    test_gap();
    test_backpressure();
    test_restart_ignored();
    test_reset_midrun();
`ifdef SA_STREAM_ACC_EN
    test_acc();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
